twiddle_fetch_ctrl: RTL

Sequencer in front of the three-bank twiddle ROM wrapper. It accepts one fetch request per twiddle set and drives the wrapper's active-low chip enable and three radix-digit addresses for exactly four consecutive phase cycles. It emits a phase-tagged read strobe aligned with the ROM output data. It sits between the FFT stage address generator and the ROM wrapper, and it supports back-to-back bursts and a synchronous flush.

---
 rtl/twiddle_fetch_ctrl_pkg.sv | 27 ++
 rtl/twiddle_fetch_ctrl_if.sv | 50 +++++
 rtl/tfc_strobe_pipe.sv | 61 ++++++
 rtl/twiddle_fetch_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/twiddle_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// twiddle_fetch_ctrl_pkg
// Shared types and constants for the twiddle ROM fetch sequencer.
//   PHASE_W   : width of the phase index (four phases per burst)
//   TFC_TAG_W : width of the tag carried in a strobe entry; TAG_W must not
//               exceed it
//   state_e   : sequencer states
//   strobe_t  : one entry of the read-strobe pipeline
// -----------------------------------------------------------------------------
package twiddle_fetch_ctrl_pkg;

  localparam int PHASE_W   = 2;
  localparam int TFC_TAG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [PHASE_W-1:0]   phase;
    logic [TFC_TAG_W-1:0] tag;
  } strobe_t;

endpackage

// File: rtl/twiddle_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// twiddle_fetch_ctrl_if
// Bundles the request handshake, the ROM wrapper drive and the read strobe of
// the twiddle fetch sequencer.
//   master : requester / consumer side (drives requests and flush)
//   slave  : sequencer side (drives req_ready, rom_*, rd_*, busy)
// Signals:
//   flush, req_valid, req_ready, req_ma0..2, req_tag   request side
//   rom_cen (active-low), rom_ma0..2                   ROM wrapper side
//   rd_valid, rd_phase, rd_tag, rd_last, busy          read strobe / status
// -----------------------------------------------------------------------------
interface twiddle_fetch_ctrl_if
  import twiddle_fetch_ctrl_pkg::*;
#(
  parameter int RADIX_W = 6,
  parameter int TAG_W   = 4
);

  logic               flush;
  logic               req_valid;
  logic               req_ready;
  logic [RADIX_W-1:0] req_ma0;
  logic [RADIX_W-1:0] req_ma1;
  logic [RADIX_W-1:0] req_ma2;
  logic [TAG_W-1:0]   req_tag;

  logic               rom_cen;
  logic [RADIX_W-1:0] rom_ma0;
  logic [RADIX_W-1:0] rom_ma1;
  logic [RADIX_W-1:0] rom_ma2;

  logic               rd_valid;
  logic [PHASE_W-1:0] rd_phase;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_last;
  logic               busy;

  modport master (
    output flush, req_valid, req_ma0, req_ma1, req_ma2, req_tag,
    input  req_ready, rom_cen, rom_ma0, rom_ma1, rom_ma2,
    input  rd_valid, rd_phase, rd_tag, rd_last, busy
  );

  modport slave (
    input  flush, req_valid, req_ma0, req_ma1, req_ma2, req_tag,
    output req_ready, rom_cen, rom_ma0, rom_ma1, rom_ma2,
    output rd_valid, rd_phase, rd_tag, rd_last, busy
  );

endinterface

// File: rtl/tfc_strobe_pipe.sv
// -----------------------------------------------------------------------------
// tfc_strobe_pipe
// ROM_LAT-deep shift register of read-strobe entries so that each strobe lines
// up with the ROM wrapper output data for the address cycle it was issued in.
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous reset, ACTIVE-HIGH despite its name
//   i_flush        synchronous clear of every entry's valid bit
//   i_entry        entry loaded into stage 0 every cycle
//   o_entry        last stage (drives rd_*)
//   o_any_valid    some stage holds a valid strobe
//   o_inner_valid  some stage other than the last holds a valid strobe
// -----------------------------------------------------------------------------
module tfc_strobe_pipe
  import twiddle_fetch_ctrl_pkg::*;
#(
  parameter int ROM_LAT = 1   // legal range 1..3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_flush,
  input  strobe_t i_entry,
  output strobe_t o_entry,
  output logic    o_any_valid,
  output logic    o_inner_valid
);

  strobe_t r_stage [ROM_LAT];

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // shift register into a single stage.
  // NOTE: the stages are reset even though this is array-shaped storage: it is
  // a handful of flops, and a stale valid bit escaping after reset would be a
  // phantom read strobe.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) r_stage[i] <= '0;
    end else if (i_flush) begin
      // Only the valids are killed; phase/tag are don't-care without them.
      for (int i = 0; i < ROM_LAT; i++) r_stage[i].valid <= 1'b0;
    end else begin
      r_stage[0] <= i_entry;
      for (int i = 1; i < ROM_LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_entry = r_stage[ROM_LAT-1];

  // NOTE: combinational outputs get a default before any conditional update so
  // no path leaves them unassigned and no latch is inferred.
  always_comb begin
    o_any_valid   = 1'b0;
    o_inner_valid = 1'b0;
    for (int i = 0; i < ROM_LAT; i++) begin
      o_any_valid = o_any_valid | r_stage[i].valid;
      if (i < ROM_LAT - 1) o_inner_valid = o_inner_valid | r_stage[i].valid;
    end
  end

endmodule

// File: rtl/twiddle_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// twiddle_fetch_ctrl
// Sequencer in front of the three-bank twiddle ROM wrapper. One accepted
// request drives ROM_CEN low and holds MA0..MA2 for PHASES consecutive cycles;
// a phase-tagged read strobe follows ROM_LAT cycles later, aligned with the
// wrapper data. A request accepted on the last phase chains the next burst
// with no gap. flush aborts the burst and the in-flight strobes.
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous reset, ACTIVE-HIGH despite its name
//   bus            twiddle_fetch_ctrl_if.slave (request, ROM drive, strobes)
//   perf_bursts    accepted requests, saturating     (TFC_PERF_CNT_EN only)
//   perf_gaps      missed back-to-back slots, sat.   (TFC_PERF_CNT_EN only)
// Build option: define TFC_PERF_CNT_EN to add the two performance counters.
// -----------------------------------------------------------------------------
module twiddle_fetch_ctrl
  import twiddle_fetch_ctrl_pkg::*;
#(
  parameter int RADIX_W = 6,
  parameter int PHASES  = 4,          // must equal the wrapper's phase count
  parameter int ROM_LAT = 1,          // legal range 1..3
  parameter int TAG_W   = TFC_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  twiddle_fetch_ctrl_if.slave   bus
`ifdef TFC_PERF_CNT_EN
  ,
  output logic [15:0]           perf_bursts,
  output logic [15:0]           perf_gaps
`endif
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);

  state_e             r_state;
  state_e             w_next_state;
  logic [PHASE_W-1:0] r_phase;
  logic               r_rom_cen;
  logic [RADIX_W-1:0] r_ma0;
  logic [RADIX_W-1:0] r_ma1;
  logic [RADIX_W-1:0] r_ma2;
  logic [TAG_W-1:0]   r_burst_tag;

  logic               w_last_phase;
  logic               w_req_ready;
  logic               w_accept;
  strobe_t            w_pipe_in;
  strobe_t            w_pipe_out;
  logic               w_pipe_any_valid;
  logic               w_pipe_inner_valid;

  assign w_last_phase = (r_phase == LAST_PHASE);

  // ---------------------------------------------------------------------------
  // Next state and handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    w_req_ready  = 1'b0;
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DRAIN: w_req_ready = 1'b1;
      ST_FETCH:          w_req_ready = w_last_phase;
      default:           w_req_ready = 1'b0;
    endcase
    // Reset and flush both veto the handshake.
    w_req_ready = w_req_ready && !bus.flush && !rst_n;
    w_accept    = w_req_ready && bus.req_valid;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_last_phase) w_next_state = w_accept ? ST_FETCH : ST_DRAIN;
      end
      ST_DRAIN: begin
        // The last stage retires this cycle, so only the inner stages matter.
        if (w_accept)                w_next_state = ST_FETCH;
        else if (!w_pipe_inner_valid) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase

    if (bus.flush) w_next_state = ST_IDLE;
  end

  // ---------------------------------------------------------------------------
  // State, phase counter and latched request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_rom_cen   <= 1'b1;
      r_ma0       <= '0;
      r_ma1       <= '0;
      r_ma2       <= '0;
      r_burst_tag <= '0;
    end else begin
      r_state   <= w_next_state;
      // Registered so ROM_CEN cannot glitch on multi-bit state decode.
      r_rom_cen <= (w_next_state != ST_FETCH);
      if (w_accept) begin
        r_phase     <= '0;
        r_ma0       <= bus.req_ma0;
        r_ma1       <= bus.req_ma1;
        r_ma2       <= bus.req_ma2;
        r_burst_tag <= bus.req_tag;
      end else if (r_state == ST_FETCH) begin
        r_phase <= w_last_phase ? '0 : r_phase + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe pipeline
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pipe_in       = '0;
    w_pipe_in.valid = (r_state == ST_FETCH);
    w_pipe_in.phase = r_phase;
    w_pipe_in.tag   = TFC_TAG_W'(r_burst_tag);
  end

  tfc_strobe_pipe #(
    .ROM_LAT (ROM_LAT)
  ) u_strobe_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (bus.flush),
    .i_entry       (w_pipe_in),
    .o_entry       (w_pipe_out),
    .o_any_valid   (w_pipe_any_valid),
    .o_inner_valid (w_pipe_inner_valid)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready = w_req_ready;
  assign bus.rom_cen   = r_rom_cen;
  assign bus.rom_ma0   = r_ma0;
  assign bus.rom_ma1   = r_ma1;
  assign bus.rom_ma2   = r_ma2;
  assign bus.rd_valid  = w_pipe_out.valid;
  assign bus.rd_phase  = w_pipe_out.phase;
  assign bus.rd_tag    = TAG_W'(w_pipe_out.tag);
  assign bus.rd_last   = w_pipe_out.valid && (w_pipe_out.phase == LAST_PHASE);
  assign bus.busy      = (r_state != ST_IDLE) || w_pipe_any_valid;

`ifdef TFC_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating, untouched by flush)
  // ---------------------------------------------------------------------------
  logic        r_after_last;   // previous cycle was FETCH on the last phase
  logic [15:0] r_perf_bursts;
  logic [15:0] r_perf_gaps;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_after_last  <= 1'b0;
      r_perf_bursts <= '0;
      r_perf_gaps   <= '0;
    end else begin
      r_after_last <= (r_state == ST_FETCH) && w_last_phase;
      if (w_accept && (r_perf_bursts != 16'hFFFF))
        r_perf_bursts <= r_perf_bursts + 16'd1;
      // A chaining slot that nobody used: out of FETCH with no request.
      if (r_after_last && (r_state != ST_FETCH) && !bus.req_valid &&
          (r_perf_gaps != 16'hFFFF))
        r_perf_gaps <= r_perf_gaps + 16'd1;
    end
  end

  assign perf_bursts = r_perf_bursts;
  assign perf_gaps   = r_perf_gaps;
`endif

endmodule
